id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID each cycle. Supplies ex_rs_o/ex_rt_o to the forwarding unit, and operands/control to EX.
- Detects a load in EX whose destination (rt) feeds the instruction in ID. On detection it freezes PC and IF/ID and injects bubbles into EX.
- Honours a branch flush from MEM.

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_if.sv | 48 ++++
 rtl/id_ex_stage_hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-word layout, NOP encoding and
// register index width used by the ID/EX stage and its neighbours.
package id_ex_stage_pkg;

    localparam int CTRL_W    = 10;
    localparam int REG_IDX_W = 5;

    // Bit positions inside the packed control word
    // {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[2:0]}
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef logic [CTRL_W-1:0]    ctrl_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // All-zero control word: no register write, no memory access
    localparam ctrl_t CTRL_NOP = '0;

    // Register $0 is hard-wired to zero in MIPS
    localparam reg_idx_t REG_ZERO = '0;

    function automatic logic ctrl_mem_read(input ctrl_t c);
        return c[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and
// hazard stall controls out.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic [DATA_W-1:0] id_pc_plus4_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    reg_idx_t          id_rs_i;
    reg_idx_t          id_rt_i;
    reg_idx_t          id_rd_i;
    ctrl_t             id_ctrl_i;

    logic [DATA_W-1:0] ex_pc_plus4_o;
    logic [DATA_W-1:0] ex_rs_data_o;
    logic [DATA_W-1:0] ex_rt_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    reg_idx_t          ex_rs_o;
    reg_idx_t          ex_rt_o;
    reg_idx_t          ex_rd_o;
    ctrl_t             ex_ctrl_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              stall_o;

    // Decode side: drives ID fields and flush, observes EX and stall controls
    modport master (
        output flush_i, id_pc_plus4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_ctrl_i,
        input  ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_ctrl_o,
               pc_write_o, ifid_write_o, stall_o
    );

    // Pipeline register side
    modport slave (
        input  flush_i, id_pc_plus4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_ctrl_i,
        output ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_ctrl_o,
               pc_write_o, ifid_write_o, stall_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination rt is read by
// the instruction currently in ID. Register $0 never creates a dependency.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic     ex_mem_read_i,
    input  reg_idx_t ex_rt_i,
    input  reg_idx_t id_rs_i,
    input  reg_idx_t id_rt_i,
    output logic     haz_o
);

    // The rt match is taken even when the ID opcode does not read rt; the
    // occasional extra bubble is cheaper than decoding the opcode here.
    always_comb begin
        haz_o = ex_mem_read_i
              & (ex_rt_i != REG_ZERO)
              & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use stall control.
// A detected hazard freezes PC and IF/ID and feeds STALL_CYCLES bubbles
// into EX; a branch flush from MEM overrides any stall in progress.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 1
)(
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    localparam int                CNT_W      = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [DATA_W-1:0] ex_pc_plus4_p1;
    logic [DATA_W-1:0] ex_rs_data_p1;
    logic [DATA_W-1:0] ex_rt_data_p1;
    logic [DATA_W-1:0] ex_imm_p1;
    reg_idx_t          ex_rs_p1;
    reg_idx_t          ex_rt_p1;
    reg_idx_t          ex_rd_p1;
    ctrl_t             ex_ctrl_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic haz;
    logic stall;

    id_ex_stage_hazard_detect u_hazard_detect (
        .ex_mem_read_i (ctrl_mem_read(ex_ctrl_p1)),
        .ex_rt_i       (ex_rt_p1),
        .id_rs_i       (bus.id_rs_i),
        .id_rt_i       (bus.id_rt_i),
        .haz_o         (haz)
    );

    // Stall is held for the detect cycle plus any remaining counted bubbles
    always_comb begin
        stall = haz | (cnt_p1 != '0);
    end

    // Control word and bubble counter: reset, then flush, then stall priority
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_ctrl_p1 <= CTRL_NOP;
            cnt_p1     <= '0;
        end else if (bus.flush_i) begin
            ex_ctrl_p1 <= CTRL_NOP;
            cnt_p1     <= '0;
        end else if (stall) begin
            ex_ctrl_p1 <= CTRL_NOP;
            if (haz && (cnt_p1 == '0)) begin
                cnt_p1 <= CNT_RELOAD;
            end else if (cnt_p1 != '0) begin
                cnt_p1 <= cnt_p1 - CNT_ONE;
            end
        end else begin
            ex_ctrl_p1 <= bus.id_ctrl_i;
            cnt_p1     <= '0;
        end
    end

    // Operand and index fields follow ID every cycle; a bubble is made
    // harmless by its zero control word alone
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_pc_plus4_p1 <= '0;
            ex_rs_data_p1  <= '0;
            ex_rt_data_p1  <= '0;
            ex_imm_p1      <= '0;
            ex_rs_p1       <= '0;
            ex_rt_p1       <= '0;
            ex_rd_p1       <= '0;
        end else begin
            ex_pc_plus4_p1 <= bus.id_pc_plus4_i;
            ex_rs_data_p1  <= bus.id_rs_data_i;
            ex_rt_data_p1  <= bus.id_rt_data_i;
            ex_imm_p1      <= bus.id_imm_i;
            ex_rs_p1       <= bus.id_rs_i;
            ex_rt_p1       <= bus.id_rt_i;
            ex_rd_p1       <= bus.id_rd_i;
        end
    end

    // ---- EX stage boundary: registered outputs and stall controls ----
    always_comb begin
        bus.ex_pc_plus4_o = ex_pc_plus4_p1;
        bus.ex_rs_data_o  = ex_rs_data_p1;
        bus.ex_rt_data_o  = ex_rt_data_p1;
        bus.ex_imm_o      = ex_imm_p1;
        bus.ex_rs_o       = ex_rs_p1;
        bus.ex_rt_o       = ex_rt_p1;
        bus.ex_rd_o       = ex_rd_p1;
        bus.ex_ctrl_o     = ex_ctrl_p1;
        bus.stall_o       = stall;
        bus.pc_write_o    = ~stall | bus.flush_i;
        bus.ifid_write_o  = ~stall | bus.flush_i;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 3 stall cycles) share one
// stimulus stream; a reference model predicts each, a monitor compares.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [9:0] C_LW  = 10'h390; // reg_write, mem_to_reg, mem_read, alu_src
    localparam logic [9:0] C_ADD = 10'h20A; // reg_write, reg_dst, alu_op=010

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32)) bus1 ();
    id_ex_stage_if #(.DATA_W(32)) bus3 ();

    id_ex_stage #(.DATA_W(32), .STALL_CYCLES(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1.slave)
    );

    id_ex_stage #(.DATA_W(32), .STALL_CYCLES(3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus3.slave)
    );

    typedef struct {
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
        int          bubbles_left;   // bubbles still owed after this cycle
    } model_t;

    typedef struct {
        bit          chk_comb;
        logic        pcw, stall;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
    } exp_t;

    model_t m [2];
    exp_t   q0 [$];
    exp_t   q1 [$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One ID cycle: drive inputs, predict both instances, queue predictions
    task automatic step(input bit rst, input bit flush,
                        input logic [31:0] pc, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [9:0] ctrl, input bit chk);
        @(negedge clk);
        rst_n = rst;
        bus1.flush_i = flush; bus3.flush_i = flush;
        bus1.id_pc_plus4_i = pc;  bus3.id_pc_plus4_i = pc;
        bus1.id_rs_data_i = rsd;  bus3.id_rs_data_i = rsd;
        bus1.id_rt_data_i = rtd;  bus3.id_rt_data_i = rtd;
        bus1.id_imm_i = imm;      bus3.id_imm_i = imm;
        bus1.id_rs_i = rs;        bus3.id_rs_i = rs;
        bus1.id_rt_i = rt;        bus3.id_rt_i = rt;
        bus1.id_rd_i = rd;        bus3.id_rd_i = rd;
        bus1.id_ctrl_i = ctrl;    bus3.id_ctrl_i = ctrl;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   nbub;
            int   total;
            bit   dep;
            total = (k == 0) ? 1 : 3;
            // A dependent instruction behind a load (not via $0) needs the load's data
            dep = (m[k].ctrl[7] === 1'b1) && (m[k].rt != 0) &&
                  ((m[k].rt == rs) || (m[k].rt == rt));
            nbub = m[k].bubbles_left;
            if (nbub == 0 && dep) nbub = total;
            e.chk_comb = chk;
            e.stall    = (nbub > 0);
            e.pcw      = (nbub == 0) || flush;
            if (!rst) begin
                m[k] = '{pc: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, rd: 0, ctrl: 0, bubbles_left: 0};
            end else begin
                m[k].pc = pc; m[k].rsd = rsd; m[k].rtd = rtd; m[k].imm = imm;
                m[k].rs = rs; m[k].rt = rt; m[k].rd = rd;
                if (flush) begin
                    m[k].ctrl = 0;
                    m[k].bubbles_left = 0;
                end else if (nbub > 0) begin
                    m[k].ctrl = 0;
                    m[k].bubbles_left = nbub - 1;
                end else begin
                    m[k].ctrl = ctrl;
                    m[k].bubbles_left = 0;
                end
            end
            e.pc = m[k].pc; e.rsd = m[k].rsd; e.rtd = m[k].rtd; e.imm = m[k].imm;
            e.rs = m[k].rs; e.rt = m[k].rt; e.rd = m[k].rd; e.ctrl = m[k].ctrl;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic compare(input string tag, input exp_t e,
                           input logic pcw, input logic ifw, input logic stl,
                           input logic [31:0] pc, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [9:0] ctrl);
        if (e.chk_comb) begin
            check({tag, ".stall"}, 32'(stl), 32'(e.stall));
            check({tag, ".pc_write"}, 32'(pcw), 32'(e.pcw));
            check({tag, ".ifid_write"}, 32'(ifw), 32'(e.pcw));
        end
        check({tag, ".ex_ctrl"}, 32'(ctrl), 32'(e.ctrl));
        check({tag, ".ex_pc_plus4"}, pc, e.pc);
        check({tag, ".ex_rs_data"}, rsd, e.rsd);
        check({tag, ".ex_rt_data"}, rtd, e.rtd);
        check({tag, ".ex_imm"}, imm, e.imm);
        check({tag, ".ex_rs"}, 32'(rs), 32'(e.rs));
        check({tag, ".ex_rt"}, 32'(rt), 32'(e.rt));
        check({tag, ".ex_rd"}, 32'(rd), 32'(e.rd));
    endtask

    // Monitor: combinational outputs just before the edge, registers just after
    initial begin
        logic pcw1, ifw1, stl1, pcw3, ifw3, stl3;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            pcw1 = bus1.pc_write_o; ifw1 = bus1.ifid_write_o; stl1 = bus1.stall_o;
            pcw3 = bus3.pc_write_o; ifw3 = bus3.ifid_write_o; stl3 = bus3.stall_o;
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare("s1", e, pcw1, ifw1, stl1, bus1.ex_pc_plus4_o, bus1.ex_rs_data_o,
                        bus1.ex_rt_data_o, bus1.ex_imm_o, bus1.ex_rs_o, bus1.ex_rt_o,
                        bus1.ex_rd_o, bus1.ex_ctrl_o);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("s3", e, pcw3, ifw3, stl3, bus3.ex_pc_plus4_o, bus3.ex_rs_data_o,
                        bus3.ex_rt_data_o, bus3.ex_imm_o, bus3.ex_rs_o, bus3.ex_rt_o,
                        bus3.ex_rd_o, bus3.ex_ctrl_o);
            end
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 2; k++)
            m[k] = '{pc: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, rd: 0, ctrl: 0, bubbles_left: 0};
        rst_n = 1'b0;

        // Reset with busy ID inputs; first cycle's outputs are unknown beforehand
        step(0, 0, 32'h1004, 32'hAAAA, 32'hBBBB, 32'h10, 5'd3, 5'd4, 5'd5, C_ADD, 0);
        step(0, 0, 32'h1008, 32'hCCCC, 32'hDDDD, 32'h20, 5'd6, 5'd7, 5'd8, C_LW, 1);
        step(1, 0, 32'h100C, 32'h1111, 32'h2222, 32'h30, 5'd1, 5'd2, 5'd3, C_ADD, 1);

        // Load-use on rs: lw rt=8 then add rs=8, ID held while stalled
        step(1, 0, 32'h2004, 32'h0, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, C_LW, 1);
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h2008, 32'h55, 32'h66, 32'h0, 5'd8, 5'd2, 5'd9, C_ADD, 1);

        // No false hazard: rt=0 load, then unrelated registers
        step(1, 0, 32'h3004, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, C_LW, 1);
        step(1, 0, 32'h3008, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd4, C_ADD, 1);
        step(1, 0, 32'h300C, 32'h0, 32'h0, 32'hC, 5'd1, 5'd8, 5'd0, C_LW, 1);
        step(1, 0, 32'h3010, 32'h3, 32'h4, 32'h0, 5'd9, 5'd10, 5'd11, C_ADD, 1);

        // Flush together with a hazard, then a clean instruction
        step(1, 0, 32'h4004, 32'h0, 32'h0, 32'h10, 5'd1, 5'd8, 5'd0, C_LW, 1);
        step(1, 1, 32'h4008, 32'h7, 32'h8, 32'h0, 5'd8, 5'd2, 5'd3, C_ADD, 1);
        step(1, 0, 32'h400C, 32'h9, 32'hA, 32'h0, 5'd4, 5'd5, 5'd6, C_ADD, 1);

        // Reset after the first bubble of a stall
        step(1, 0, 32'h5004, 32'h0, 32'h0, 32'h14, 5'd1, 5'd8, 5'd0, C_LW, 1);
        step(1, 0, 32'h5008, 32'hB, 32'hC, 32'h0, 5'd8, 5'd2, 5'd3, C_ADD, 1);
        step(0, 0, 32'h5008, 32'hB, 32'hC, 32'h0, 5'd8, 5'd2, 5'd3, C_ADD, 1);
        step(1, 0, 32'h500C, 32'hD, 32'hE, 32'h0, 5'd4, 5'd5, 5'd6, C_ADD, 1);
        step(1, 0, 32'h5010, 32'hF, 32'h10, 32'h0, 5'd7, 5'd9, 5'd1, C_ADD, 1);

        // Random traffic with dense register reuse and frequent loads
        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) c[7] = 1'b1;
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                 $urandom, $urandom, $urandom, $urandom,
                 pick_reg(), pick_reg(), pick_reg(), c, 1);
        end

        // Let the monitor drain the last predictions
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
